// File: rtl/prim_esc_pkg.sv
// Shared types and constants for the escalation sender: FSM state encoding,
// differential pair bit positions and the idle/reset value of the TX pair.
package prim_esc_pkg;

   typedef enum logic [3:0] {
      Idle      = 4'd0,
      PingSent  = 4'd1,
      PingResp0 = 4'd2,
      PingResp1 = 4'd3,
      PingResp2 = 4'd4,
      EscSent   = 4'd5,
      EscHi     = 4'd6,
      EscLo     = 4'd7,
      EscSync   = 4'd8
   } esc_state_e;

   localparam int unsigned EscP = 1;
   localparam int unsigned EscN = 0;

   localparam logic [1:0] EscTxRst = 2'b01;

endpackage

// File: rtl/prim_diff_decode.sv
// Differential pair decoder: level, edge events and signal-integrity error.
// AsyncOn inserts a two-stage synchronizer ahead of the decode.
module prim_diff_decode #(
   parameter bit AsyncOn = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic diff_pi,
   input  logic diff_ni,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic event_o,
   output logic sigint_o
);

   logic diff_p;
   logic diff_n;
   logic level_q;

   if (AsyncOn) begin : gen_async
      logic [1:0] sync_p;
      logic [1:0] sync_n;

      // Synchronizer stages reset to the idle pair value (p=0, n=1).
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            sync_p <= 2'b00;
            sync_n <= 2'b11;
         end else begin
            sync_p <= {sync_p[0], diff_pi};
            sync_n <= {sync_n[0], diff_ni};
         end
      end

      assign diff_p = sync_p[1];
      assign diff_n = sync_n[1];
   end else begin : gen_sync
      assign diff_p = diff_pi;
      assign diff_n = diff_ni;
   end

   assign level_o  = diff_p;
   assign sigint_o = (diff_p == diff_n);

   // Last valid level, held across integrity errors, for edge detection.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         level_q <= 1'b0;
      end else if (!sigint_o) begin
         level_q <= diff_p;
      end
   end

   assign rise_o  = ~sigint_o &  diff_p & ~level_q;
   assign fall_o  = ~sigint_o & ~diff_p &  level_q;
   assign event_o = rise_o | fall_o;

endmodule

// File: rtl/prim_esc_sender.sv
// Escalation sender: drives the esc pair and checks the receiver's response.
// Optional saturating integrity-failure counter under PRIM_ESC_SENDER_FAILCNT_EN.
module prim_esc_sender
   import prim_esc_pkg::*;
#(
   parameter int unsigned FailCntW = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                ping_req_i,
   output logic                ping_ok_o,
   input  logic                esc_req_i,
   output logic                integ_fail_o,
   output logic [1:0]          esc_tx_o,
   input  logic [1:0]          esc_rx_i
`ifdef PRIM_ESC_SENDER_FAILCNT_EN
   ,
   output logic [FailCntW-1:0] fail_cnt_o
`endif
);

   esc_state_e state_q, state_d;
   logic esc_p_q, esc_p_d;
   logic esc_req_q;
   logic ping_done_q, ping_done_d;
   logic ping_ok_q, ping_ok_d;
   logic integ_fail_q, integ_fail_d;

   logic level;
   logic sigint;
   logic unused_rise;
   logic unused_fall;
   logic unused_event;

   prim_diff_decode #(
      .AsyncOn (1'b0)
   ) u_decode_rx (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .diff_pi  (esc_rx_i[EscP]),
      .diff_ni  (esc_rx_i[EscN]),
      .level_o  (level),
      .rise_o   (unused_rise),
      .fall_o   (unused_fall),
      .event_o  (unused_event),
      .sigint_o (sigint)
   );

   logic ping_start;
   logic check;
   logic exp_level;
   logic mismatch;
   logic bad_state;

   always_comb begin
      state_d      = state_q;
      ping_ok_d    = 1'b0;
      ping_done_d  = ping_done_q;
      check        = 1'b1;
      exp_level    = 1'b0;
      bad_state    = 1'b0;
      ping_start   = (state_q == Idle) & ping_req_i & ~ping_done_q & ~esc_req_i;
      esc_p_d      = esc_req_i | esc_req_q | ping_start;

      // Level the receiver must be returning in the current state.
      case (state_q)
         PingResp0, PingResp2, EscHi: exp_level = 1'b1;
         EscSync:                     check     = 1'b0;
         default:                     exp_level = 1'b0;
      endcase

      mismatch = check & (sigint | (level != exp_level));

      case (state_q)
         Idle: begin
            if (esc_req_i) begin
               state_d = EscSent;
            end else if (ping_start) begin
               state_d = PingSent;
            end
         end
         PingSent: state_d = mismatch ? Idle : PingResp0;
         PingResp0: begin
            if (esc_p_q)       state_d = EscSync;
            else if (mismatch) state_d = Idle;
            else               state_d = PingResp1;
         end
         PingResp1: begin
            if (esc_p_q)       state_d = EscSync;
            else if (mismatch) state_d = Idle;
            else               state_d = PingResp2;
         end
         PingResp2: begin
            if (esc_p_q) begin
               state_d = EscSync;
            end else begin
               state_d = Idle;
               if (!mismatch) begin
                  ping_done_d = 1'b1;
                  ping_ok_d   = 1'b1;
               end
            end
         end
         EscSent: begin
            if (!mismatch)    state_d = EscHi;
            else if (esc_p_q) state_d = EscSync;
            else              state_d = Idle;
         end
         EscHi: begin
            if (!esc_p_q)      state_d = Idle;
            else if (mismatch) state_d = EscSync;
            else               state_d = EscLo;
         end
         EscLo: begin
            if (!esc_p_q)      state_d = Idle;
            else if (mismatch) state_d = EscSync;
            else               state_d = EscHi;
         end
         EscSync: begin
            if (!esc_p_q)   state_d = Idle;
            else if (level) state_d = EscLo;
            else            state_d = EscHi;
         end
         default: begin
            state_d   = Idle;
            bad_state = 1'b1;
         end
      endcase

      // A dropped request re-arms the ping for the next request.
      if (!ping_req_i) begin
         ping_done_d = 1'b0;
      end

      integ_fail_d = mismatch | bad_state;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= Idle;
         esc_p_q      <= EscTxRst[EscP];
         esc_req_q    <= 1'b0;
         ping_done_q  <= 1'b0;
         ping_ok_q    <= 1'b0;
         integ_fail_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         esc_p_q      <= esc_p_d;
         esc_req_q    <= esc_req_i;
         ping_done_q  <= ping_done_d;
         ping_ok_q    <= ping_ok_d;
         integ_fail_q <= integ_fail_d;
      end
   end

   assign esc_tx_o[EscP] = esc_p_q;
   assign esc_tx_o[EscN] = ~esc_p_q;
   assign ping_ok_o      = ping_ok_q;
   assign integ_fail_o   = integ_fail_q;

`ifdef PRIM_ESC_SENDER_FAILCNT_EN
   logic [FailCntW-1:0] fail_cnt_q;

   // Saturating count of cycles with integ_fail_o set.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fail_cnt_q <= '0;
      end else if (integ_fail_q && (fail_cnt_q != {FailCntW{1'b1}})) begin
         fail_cnt_q <= fail_cnt_q + FailCntW'(1);
      end
   end

   assign fail_cnt_o = fail_cnt_q;
`else
   localparam int unsigned unused_fail_cnt_w = FailCntW;
`endif

endmodule

// File: tb/tb_prim_esc_sender.sv
// Directed bench for prim_esc_sender; also checks fail_cnt_o when
// PRIM_ESC_SENDER_FAILCNT_EN is defined.
module tb_prim_esc_sender;
   import prim_esc_pkg::*;

   localparam logic [1:0] R0 = 2'b01;
   localparam logic [1:0] R1 = 2'b10;
   localparam logic [1:0] RS = 2'b11;
   localparam logic [1:0] T0 = 2'b01;
   localparam logic [1:0] T1 = 2'b10;

   logic       clk;
   logic       rst_n;
   logic       ping_req;
   logic       ping_ok;
   logic       esc_req;
   logic       integ_fail;
   logic [1:0] esc_tx;
   logic [1:0] esc_rx;
`ifdef PRIM_ESC_SENDER_FAILCNT_EN
   logic [7:0] fail_cnt;
`endif

   int tests = 0;
   int fails = 0;

   prim_esc_sender #(
      .FailCntW (8)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .ping_req_i   (ping_req),
      .ping_ok_o    (ping_ok),
      .esc_req_i    (esc_req),
      .integ_fail_o (integ_fail),
      .esc_tx_o     (esc_tx),
      .esc_rx_i     (esc_rx)
`ifdef PRIM_ESC_SENDER_FAILCNT_EN
      ,
      .fail_cnt_o   (fail_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge, check that cycle's outputs, advance.
   task automatic cyc(input logic e, input logic p, input logic [1:0] rx,
                      input logic [1:0] etx, input logic eok, input logic efail,
                      input string tag);
      esc_req  = e;
      ping_req = p;
      esc_rx   = rx;
      chk({tag, " tx"}, 8'(esc_tx), 8'(etx));
      chk({tag, " ok"}, 8'(ping_ok), 8'(eok));
      chk({tag, " fail"}, 8'(integ_fail), 8'(efail));
      @(negedge clk);
   endtask

   initial begin
      rst_n    = 1'b0;
      ping_req = 1'b0;
      esc_req  = 1'b0;
      esc_rx   = R0;
      #1;
      chk("rst tx", 8'(esc_tx), 8'(T0));
      chk("rst ok", 8'(ping_ok), 8'h0);
      chk("rst fail", 8'(integ_fail), 8'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst state", 8'(dut.state_q), 8'(Idle));
      cyc(0, 0, R0, T0, 0, 0, "idle0");
      cyc(0, 0, R0, T0, 0, 0, "idle1");

      // Ping with correct receiver response.
      cyc(0, 1, R0, T0, 0, 0, "ping c0");
      cyc(0, 1, R0, T1, 0, 0, "ping c1");
      cyc(0, 1, R1, T0, 0, 0, "ping c2");
      cyc(0, 1, R0, T0, 0, 0, "ping c3");
      cyc(0, 1, R1, T0, 0, 0, "ping c4");
      cyc(0, 1, R0, T0, 1, 0, "ping c5");
      cyc(0, 0, R0, T0, 0, 0, "ping c6");
      cyc(0, 0, R0, T0, 0, 0, "ping c7");

      // Escalation held cycles 0-5, stretched to cycle 7.
      cyc(1, 0, R0, T0, 0, 0, "esc c0");
      cyc(1, 0, R0, T1, 0, 0, "esc c1");
      cyc(1, 0, R1, T1, 0, 0, "esc c2");
      cyc(1, 0, R0, T1, 0, 0, "esc c3");
      cyc(1, 0, R1, T1, 0, 0, "esc c4");
      cyc(1, 0, R0, T1, 0, 0, "esc c5");
      cyc(0, 0, R1, T1, 0, 0, "esc c6");
      cyc(0, 0, R0, T1, 0, 0, "esc c7");
      cyc(0, 0, R1, T0, 0, 0, "esc c8");
      chk("esc c9 state", 8'(dut.state_q), 8'(Idle));
      cyc(0, 0, R0, T0, 0, 0, "esc c9");
      cyc(0, 0, R0, T0, 0, 0, "esc c10");

      // Single-cycle escalation request.
      cyc(1, 0, R0, T0, 0, 0, "esc1 c0");
      cyc(0, 0, R0, T1, 0, 0, "esc1 c1");
      cyc(0, 0, R1, T1, 0, 0, "esc1 c2");
      cyc(0, 0, R0, T0, 0, 0, "esc1 c3");
      cyc(0, 0, R0, T0, 0, 0, "esc1 c4");
      cyc(0, 0, R0, T0, 0, 0, "esc1 c5");

      // Escalation preempts a ping; pending ping reruns afterwards.
      cyc(0, 1, R0, T0, 0, 0, "pre c0");
      cyc(0, 1, R0, T1, 0, 0, "pre c1");
      cyc(1, 1, R1, T0, 0, 0, "pre c2");
      cyc(1, 1, R0, T1, 0, 0, "pre c3");
      cyc(1, 1, R1, T1, 0, 0, "pre c4");
      cyc(1, 1, R0, T1, 0, 0, "pre c5");
      cyc(0, 1, R1, T1, 0, 0, "pre c6");
      cyc(0, 1, R0, T1, 0, 0, "pre c7");
      cyc(0, 1, R1, T0, 0, 0, "pre c8");
      cyc(0, 1, R0, T0, 0, 0, "pre c9");
      cyc(0, 1, R0, T1, 0, 0, "pre c10");
      cyc(0, 1, R1, T0, 0, 0, "pre c11");
      cyc(0, 1, R0, T0, 0, 0, "pre c12");
      cyc(0, 1, R1, T0, 0, 0, "pre c13");
      cyc(0, 1, R0, T0, 1, 0, "pre c14");
      cyc(0, 0, R0, T0, 0, 0, "pre c15");

      // Sigint held three cycles in Idle.
      cyc(0, 0, RS, T0, 0, 0, "sig c0");
      cyc(0, 0, RS, T0, 0, 1, "sig c1");
      cyc(0, 0, RS, T0, 0, 1, "sig c2");
      cyc(0, 0, R0, T0, 0, 1, "sig c3");
      cyc(0, 0, R0, T0, 0, 0, "sig c4");
`ifdef PRIM_ESC_SENDER_FAILCNT_EN
      chk("sig cnt", fail_cnt, 8'd3);
`endif
      cyc(0, 0, R0, T0, 0, 0, "sig c5");

      // Wrong ping response aborts and the ping retries.
      cyc(0, 1, R0, T0, 0, 0, "pab c0");
      cyc(0, 1, R0, T1, 0, 0, "pab c1");
      cyc(0, 1, R0, T0, 0, 0, "pab c2");
      cyc(0, 1, R0, T0, 0, 1, "pab c3");
      cyc(0, 1, R0, T1, 0, 0, "pab c4");
      cyc(0, 1, R1, T0, 0, 0, "pab c5");
      cyc(0, 1, R0, T0, 0, 0, "pab c6");
      cyc(0, 1, R1, T0, 0, 0, "pab c7");
      cyc(0, 1, R0, T0, 1, 0, "pab c8");
      cyc(0, 0, R0, T0, 0, 0, "pab c9");

      // Wrong level mid-escalation: flagged once, escalation keeps going.
      cyc(1, 0, R0, T0, 0, 0, "ebad c0");
      cyc(1, 0, R0, T1, 0, 0, "ebad c1");
      cyc(1, 0, R1, T1, 0, 0, "ebad c2");
      cyc(1, 0, R1, T1, 0, 0, "ebad c3");
      cyc(0, 0, R0, T1, 0, 1, "ebad c4");
      cyc(0, 0, R1, T1, 0, 0, "ebad c5");
      cyc(0, 0, R0, T0, 0, 0, "ebad c6");
      chk("ebad c7 state", 8'(dut.state_q), 8'(Idle));
      cyc(0, 0, R0, T0, 0, 0, "ebad c7");
`ifdef PRIM_ESC_SENDER_FAILCNT_EN
      chk("ebad cnt", fail_cnt, 8'd5);
`endif

      // Reset mid-escalation.
      cyc(1, 0, R0, T0, 0, 0, "rst c0");
      cyc(1, 0, R0, T1, 0, 0, "rst c1");
      cyc(1, 0, R1, T1, 0, 0, "rst c2");
      rst_n   = 1'b0;
      esc_req = 1'b0;
      esc_rx  = R0;
      #1;
      chk("rst mid tx", 8'(esc_tx), 8'(T0));
      chk("rst mid ok", 8'(ping_ok), 8'h0);
`ifdef PRIM_ESC_SENDER_FAILCNT_EN
      chk("rst mid cnt", fail_cnt, 8'd0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst rel state", 8'(dut.state_q), 8'(Idle));
      cyc(0, 0, R0, T0, 0, 0, "rel c0");
      cyc(0, 0, R0, T0, 0, 0, "rel c1");
      cyc(0, 0, R0, T0, 0, 0, "rel c2");

      // Reset while ping_ok_o is high clears it immediately.
      cyc(0, 1, R0, T0, 0, 0, "rok c0");
      cyc(0, 1, R0, T1, 0, 0, "rok c1");
      cyc(0, 1, R1, T0, 0, 0, "rok c2");
      cyc(0, 1, R0, T0, 0, 0, "rok c3");
      cyc(0, 1, R1, T0, 0, 0, "rok c4");
      chk("rok c5 ok", 8'(ping_ok), 8'h1);
      rst_n    = 1'b0;
      ping_req = 1'b0;
      esc_rx   = R0;
      #1;
      chk("rok rst ok", 8'(ping_ok), 8'h0);
      chk("rok rst tx", 8'(esc_tx), 8'(T0));
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 0, R0, T0, 0, 0, "rok rel c0");
      cyc(0, 0, R0, T0, 0, 0, "rok rel c1");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
